// File: rtl/time_set_pkg.sv
// Shared constants, FSM state encoding and calendar helpers for the UART time-set parser.
package time_set_pkg;

    localparam logic [7:0] ASCII_T_UP  = 8'h54;
    localparam logic [7:0] ASCII_T_LO  = 8'h74;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam int unsigned NUM_DIGITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIGITS,
        ST_WAIT_CR,
        ST_CHECK,
        ST_LOAD,
        ST_RESP
    } state_e;

    // Non-leap calendar; out-of-range months return 0 so any day fails the check.
    function automatic logic [4:0] days_in_month(input logic [3:0] month);
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days_in_month = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                     days_in_month = 5'd30;
            4'd2:                                        days_in_month = 5'd28;
            default:                                     days_in_month = 5'd0;
        endcase
    endfunction

    function automatic logic [6:0] two_digit(input logic [3:0] tens, input logic [3:0] units);
        two_digit = 7'({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

endpackage

// File: rtl/frame_timeout.sv
// Clearable, saturating inter-byte idle counter; expired_o is high once
// TIMEOUT_CYCLES-1 idle cycles have elapsed since the last clear.
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (cnt_q != LAST)
            cnt_q <= cnt_q + 1'b1;
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_time_parser.sv
// Parses "T/t MMDDhhmmss CR" frames from a UART byte stream, validates the
// date/time and issues a load strobe plus a 'K' or 'E' response byte.
module uart_time_parser
    import time_set_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       load_settings,
    output logic [5:0] load_sec,
    output logic [5:0] load_min,
    output logic [4:0] load_hour,
    output logic [4:0] load_day,
    output logic [3:0] load_month,
    output logic       busy,
    output logic       frame_err
);

    state_e                           state_q;
    logic [3:0]                       idx_q;
    logic [NUM_DIGITS-1:0][3:0]       digits_q;
    logic [7:0]                       tx_data_q;
    logic                             tx_valid_q, load_settings_q, frame_err_q;
    logic [5:0]                       sec_q, min_q;
    logic [4:0]                       hour_q, day_q;
    logic [3:0]                       month_q;

    logic       in_frame, expired, is_digit, frame_ok, reject;
    logic [7:0] digit_val;
    logic [6:0] month_v, day_v, hour_v, min_v, sec_v;

    assign in_frame = (state_q == ST_DIGITS) || (state_q == ST_WAIT_CR);

    // Held clear outside the frame states, so entering DIGITS starts from zero.
    frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!in_frame || rx_valid),
        .expired_o(expired)
    );

    assign is_digit  = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
    assign digit_val = rx_data - ASCII_0;

    assign month_v = two_digit(digits_q[0], digits_q[1]);
    assign day_v   = two_digit(digits_q[2], digits_q[3]);
    assign hour_v  = two_digit(digits_q[4], digits_q[5]);
    assign min_v   = two_digit(digits_q[6], digits_q[7]);
    assign sec_v   = two_digit(digits_q[8], digits_q[9]);

    assign frame_ok = (month_v >= 7'd1) && (month_v <= 7'd12)
                   && (day_v >= 7'd1) && (day_v <= {2'b00, days_in_month(month_v[3:0])})
                   && (hour_v <= 7'd23) && (min_v <= 7'd59) && (sec_v <= 7'd59);

    // A received byte always wins over a coincident timeout.
    always_comb begin
        reject = 1'b0;
        case (state_q)
            ST_DIGITS:  reject = rx_valid ? !is_digit : expired;
            ST_WAIT_CR: reject = rx_valid ? (rx_data != ASCII_CR) : expired;
            ST_CHECK:   reject = !frame_ok;
            default:    reject = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            digits_q        <= '0;
            tx_data_q       <= 8'h00;
            tx_valid_q      <= 1'b0;
            load_settings_q <= 1'b0;
            frame_err_q     <= 1'b0;
            sec_q           <= '0;
            min_q           <= '0;
            hour_q          <= '0;
            day_q           <= 5'd1;
            month_q         <= 4'd1;
        end else begin
            load_settings_q <= 1'b0;
            frame_err_q     <= 1'b0;
            if (reject) begin
                frame_err_q <= 1'b1;
                tx_valid_q  <= 1'b1;
                tx_data_q   <= ASCII_E;
                state_q     <= ST_RESP;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_valid && (rx_data == ASCII_T_UP || rx_data == ASCII_T_LO)) begin
                            idx_q   <= '0;
                            state_q <= ST_DIGITS;
                        end
                    end
                    ST_DIGITS: begin
                        if (rx_valid) begin
                            digits_q[idx_q] <= digit_val[3:0];
                            idx_q           <= idx_q + 4'd1;
                            if (idx_q == 4'(NUM_DIGITS - 1))
                                state_q <= ST_WAIT_CR;
                        end
                    end
                    ST_WAIT_CR: begin
                        if (rx_valid)
                            state_q <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        month_q         <= month_v[3:0];
                        day_q           <= day_v[4:0];
                        hour_q          <= hour_v[4:0];
                        min_q           <= min_v[5:0];
                        sec_q           <= sec_v[5:0];
                        load_settings_q <= 1'b1;
                        state_q         <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ASCII_K;
                        state_q    <= ST_RESP;
                    end
                    ST_RESP: begin
                        if (tx_ready) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign load_settings = load_settings_q;
    assign frame_err     = frame_err_q;
    assign load_sec      = sec_q;
    assign load_min      = min_q;
    assign load_hour     = hour_q;
    assign load_day      = day_q;
    assign load_month    = month_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/uart_time_parser.md
UART_TIME_PARSER -- requirements
Module: uart_time_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning the maximum idle clock cycles between bytes inside a frame (1 s at 100 MHz).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port rx_data, input, 8, received UART byte.
REQ-005 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port tx_data, output, 8, response byte.
REQ-007 SHALL have port tx_valid, output, 1, response byte valid.
REQ-008 SHALL have port tx_ready, input, 1, transmitter accepts tx_data.
REQ-009 SHALL have port load_settings, output, 1, one-cycle load strobe to the time-keeping core.
REQ-010 SHALL have ports load_sec (6), load_min (6), load_hour (5), load_day (5) and load_month (4), all outputs, binary time values.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a rejected frame.

Function
REQ-013 SHALL accept the frame format: 'T' (0x54) or 't' (0x74), then 10 ASCII digits MMDDhhmmss, then CR (0x0D).
REQ-014 SHALL implement the states IDLE, DIGITS, WAIT_CR, CHECK, LOAD and RESP.
REQ-015 IDLE: a 'T' or 't' byte SHALL move to DIGITS with the digit index cleared; all other bytes SHALL be ignored silently.
REQ-016 DIGITS: a byte 0x30-0x39 SHALL store (byte-0x30) at the current index and increment the index; accepting the 10th digit SHALL move to WAIT_CR.
REQ-017 DIGITS: any non-digit byte, including 'T', SHALL reject the frame.
REQ-018 WAIT_CR: 0x0D SHALL move to CHECK; any other byte SHALL reject the frame.
REQ-019 CHECK (one cycle): each field SHALL be computed as tens*10+units, and the frame SHALL be valid only if all of the following hold:
- month 1-12
- day 1 to days_in_month(month), with the table 31,28,31,30,31,30,31,31,30,31,30,31 (no leap year)
- hour 0-23
- min 0-59
- sec 0-59
REQ-020 A valid frame SHALL register the load_* outputs and enter LOAD; load_settings SHALL be high in exactly that one cycle.
REQ-021 load_* outputs SHALL hold their values until the next LOAD; an invalid frame SHALL leave them unchanged.
REQ-022 Latency: for a CR accepted at edge N, load_settings SHALL be high in cycle N+2, and tx_valid SHALL assert in cycle N+3 with tx_data 'K' (0x4B).
REQ-023 Rejection: frame_err SHALL pulse in the cycle after detection, and RESP SHALL be entered with tx_data 'E' (0x45) and tx_valid high.
REQ-024 RESP: tx_valid and tx_data SHALL stay stable until a cycle with tx_ready high; the state SHALL then return to IDLE and tx_valid SHALL fall.
REQ-025 Bytes arriving in CHECK, LOAD or RESP SHALL be dropped.
REQ-026 Timeout: in DIGITS and WAIT_CR, a counter SHALL clear on each accepted byte and on entry to either state; reaching TIMEOUT_CYCLES-1 without a byte SHALL reject the frame.
REQ-027 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES with no wrap-around.
REQ-028 If rx_valid coincides with the timeout cycle, the byte SHALL take priority and the counter SHALL clear.

Reset
REQ-029 While rst=0 on a clock edge, the state SHALL go to IDLE and the digit index and timeout counter SHALL clear.
REQ-030 During reset, outputs SHALL take these values:
- tx_valid=0, tx_data=0x00
- load_settings=0, busy=0, frame_err=0
- load_sec=0, load_min=0, load_hour=0, load_day=1, load_month=1
REQ-031 A reset mid-frame or mid-RESP SHALL discard the partial frame and any pending response, with no load_settings pulse.

Structure
REQ-032 Shared package time_set_pkg SHALL hold:
- ASCII constants (start, CR, 'K', 'E', digit base)
- the state enumeration
- the days_in_month lookup function
REQ-033 A single sub-module, frame_timeout, SHALL implement the clearable inter-byte timeout counter; all other logic is flat.

Verification
REQ-034 Bench SHALL drive "T0817042000\r" -> load_settings one pulse with month=8, day=17, hour=4, min=20, sec=0, then tx 'K'.
REQ-035 Bench SHALL drive "T0230120000\r" -> frame_err pulse, tx 'E', load_* unchanged, no load_settings.
REQ-036 Bench SHALL drive "T12312359" followed by no byte for TIMEOUT_CYCLES (bench uses 1000) -> frame_err pulse, tx 'E'.
REQ-037 Bench SHALL hold tx_ready=0 for 50 cycles during RESP while sending 'T' -> tx_valid held with stable tx_data, the byte ignored, IDLE reached the cycle after tx_ready=1.
REQ-038 Bench SHALL assert rst=0 after the 5th digit, then send a valid "T0101000000\r" -> reset values are restored, then load_settings fires with month=1, day=1, all other fields 0.
REQ-039 Bench SHALL drive "xT0817042000A" -> 'x' ignored, 'A' in WAIT_CR gives tx 'E'.
